cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_pkg.sv | 13 +
 rtl/slt_cmp.sv | 12 +
 rtl/cmp_arbiter.sv | 137 +++++++++++++
 tb/tb_cmp_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared types and constants for the round-robin signed-compare arbiter.
package cmp_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefW    = 32;

  // Widest supported operand; the result constant is sliced down to W.
  localparam int unsigned    MaxW    = 64;
  localparam logic [MaxW-1:0] AllOnes = '1;

endpackage

// File: rtl/slt_cmp.sv
// Combinational two's-complement signed less-than comparator.
module slt_cmp import cmp_arbiter_pkg::*; #(
  parameter int unsigned W = DefW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one signed comparator among NREQ requesters,
// one request in flight at a time (IDLE -> CALC -> RESP).
module cmp_arbiter import cmp_arbiter_pkg::*; #(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned W    = DefW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_data,
  output logic                    rsp_flag,
  output logic                    busy
);

  localparam int unsigned IdW = $clog2(NREQ);

  state_e         state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_flag_q, rsp_flag_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;

  logic           grant_found, grant;
  logic [IdW-1:0] grant_idx, cand;
  logic [W-1:0]   a_sel, b_sel;
  logic           lt;

  // First valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IdW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  // Gated by rst so no grant is offered while reset is held.
  assign grant = grant_found && (state_q == StIdle) && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  slt_cmp #(
    .W (W)
  ) u_slt_cmp (
    .a  (a_q),
    .b  (b_q),
    .lt (lt)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d  = StCalc;
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + IdW'(1);
        end
      end
      StCalc: begin
        rsp_data_d = lt ? AllOnes[W-1:0] : '0;
        rsp_flag_d = ~lt;
        rsp_id_d   = id_q;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter (NREQ=4, W=32).
module tb_cmp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_flag, busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] Ones = 32'hFFFF_FFFF;

  cmp_arbiter #(
    .NREQ (4),
    .W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #2;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    n_tests++; if (rsp_flag !== 1'b0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_flag_id got %b/%0d exp 0/0", rsp_flag, rsp_id);
    end
    tick(); tick();
    req_valid = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_op(0, 32'hFFFF_FFFB, 32'd3);
    req_valid = 4'b0001;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_calc busy/valid got %b/%b exp 1/0", busy, rsp_valid);
    end
    tick();
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
    n_tests++; if (rsp_data !== Ones) begin n_fail++; $display("FAIL single_data got %h exp ffffffff", rsp_data); end
    n_tests++; if (rsp_flag !== 1'b0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL single_flag_id got %b/%0d exp 0/0", rsp_flag, rsp_id);
    end
    tick();
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle busy/valid got %b/%b exp 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_equal();
    // rr_ptr is 1 here
    set_op(1, 32'd7, 32'd7);
    req_valid = 4'b0010;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL eq_grant got %b exp 0010", req_ready); end
    tick(); req_valid = 4'b0000; tick();
    n_tests++; if (rsp_data !== 32'h0 || rsp_flag !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL eq_result got %h/%b/%0d exp 0/1/1", rsp_data, rsp_flag, rsp_id);
    end
    tick();
    set_op(2, 32'h7FFF_FFFF, 32'h8000_0000);
    req_valid = 4'b0100;
    tick(); req_valid = 4'b0000; tick();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_flag !== 1'b1 || rsp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL gt_result got %b/%h/%b/%0d exp 1/0/1/2", rsp_valid, rsp_data, rsp_flag, rsp_id);
    end
    tick();
  endtask

  task automatic test_wrap();
    // rr_ptr is 3 here
    set_op(0, 32'd1, 32'd2);
    set_op(2, 32'h8000_0000, 32'd1);
    req_valid = 4'b0101;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant got %b exp 0001", req_ready); end
    tick(); tick();
    n_tests++; if (rsp_id !== 2'd0 || rsp_data !== Ones) begin
      n_fail++; $display("FAIL wrap_result got %0d/%h exp 0/ffffffff", rsp_id, rsp_data);
    end
    tick();
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_next got %b exp 0100", req_ready); end
    tick(); req_valid = 4'b0000; tick();
    n_tests++; if (rsp_id !== 2'd2 || rsp_data !== Ones || rsp_flag !== 1'b0) begin
      n_fail++; $display("FAIL wrap2_result got %0d/%h/%b exp 2/ffffffff/0", rsp_id, rsp_data, rsp_flag);
    end
    tick();
  endtask

  task automatic test_midflight_reset();
    // rr_ptr is 3 here
    set_op(3, 32'd9, 32'd1);
    req_valid = 4'b1000;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant got %b exp 1000", req_ready); end
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_calc_busy got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst_ctrl got %b/%b/%b exp 0/0/0000", busy, rsp_valid, req_ready);
    end
    n_tests++; if (rsp_data !== 32'h0 || rsp_flag !== 1'b0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_rst_rsp got %h/%b/%0d exp 0/0/0", rsp_data, rsp_flag, rsp_id);
    end
    tick();
    req_valid = 4'b0000;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_after_rel cyc %0d got %b/%b exp 0/0", c, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_fairness();
    logic [31:0] exp_d [4];
    logic [1:0]  id_e;
    logic [3:0]  rdy_e;
    exp_d[0] = Ones; exp_d[1] = 32'h0; exp_d[2] = Ones; exp_d[3] = 32'h0;
    set_op(0, 32'hFFFF_FFFB, 32'd3);
    set_op(1, 32'd7, 32'd7);
    set_op(2, 32'h8000_0000, 32'h7FFF_FFFF);
    set_op(3, 32'h7FFF_FFFF, 32'h8000_0000);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      id_e  = 2'(k % 4);
      rdy_e = 4'b0001 << id_e;
      n_tests++; if (req_ready !== rdy_e) begin
        n_fail++; $display("FAIL fair_grant %0d got %b exp %b", k, req_ready, rdy_e);
      end
      tick();
      n_tests++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL fair_calc %0d got %b/%b exp 0000/0", k, req_ready, rsp_valid);
      end
      tick();
      n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== id_e || rsp_data !== exp_d[id_e]) begin
        n_fail++;
        $display("FAIL fair_rsp %0d got %b/%0d/%h exp 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data,
                 id_e, exp_d[id_e]);
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here
    set_op(1, 32'hFFFF_FFFF, 32'd0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
    tick();
    // Operand change in flight must not affect the latched request.
    req_valid = 4'b1111;
    set_op(1, 32'd5, 32'd0);
    tick();
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== Ones || rsp_id !== 2'd1 || rsp_flag !== 1'b0 ||
          req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got %b/%h/%0d/%b/%b exp 1/ffffffff/1/0/0000", c, rsp_valid,
                 rsp_data, rsp_id, rsp_flag, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got %b/%b exp 0/0", busy, rsp_valid);
    end
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_equal();
    test_wrap();
    test_midflight_reset();
    test_fairness();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
